keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Input-side companion to the seven-segment display driver: drives a 4x4 matrix keypad row by row, samples the columns, debounces, and decodes one key per press.
Delivers each key code through a valid/ready handshake.
Maintains a 32-bit hex accumulator that the CPU MMIO layer reads and mirrors to the display driver's 32-bit input.
Sits in the IO subsystem next to the display driver, on the same single clock.

Parameters:
SCAN_DIV, 50000, clock cycles each row stays driven (one full scan = 4*SCAN_DIV cycles); must be >= 4
DEB_SCANS, 4, consecutive full scans a condition must persist to count as press or release; must be >= 1
REPEAT_DELAY, 40, scans held before first auto-repeat (used only with KEYPAD_REPEAT_EN)
REPEAT_RATE, 10, scans between subsequent auto-repeats (used only with KEYPAD_REPEAT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
row  out  4  row drive, active-low, exactly one bit low at all times
col  in  4  column sense, active-low (board pull-ups), asynchronous to clk
key_code  out  4  decoded key, valid while key_valid=1
key_valid  out  1  key event pending
key_ready  in  1  consumer accepts event when key_valid & key_ready on a clk edge
key_held  out  1  1 while a debounced key is down
overrun  out  1  sticky: an event was dropped because key_valid was still pending
value  out  32  hex accumulator
clr  in  1  synchronous clear of value and overrun

Behaviour:
- Reset values (async, immediate): row=4'b1110, key_code=0, key_valid=0, key_held=0, overrun=0, value=0, FSM=IDLE, all counters 0.
- Column synchroniser: col passes through a 2-flop synchroniser before any use.
- Scanning:
  - Row index r advances 0->1->2->3->0 every SCAN_DIV cycles; row drives ~(1<<r).
  - Synchronised col is sampled on the last cycle of each row slot, so the drive has SCAN_DIV-1 cycles to settle.
  - At the end of the row-3 slot the scan is classified: NONE (no bit low), SINGLE(r,c) (exactly one bit low across all rows), or MULTI.
- Key map:
  - row0: 1 2 3 A; row1: 4 5 6 B; row2: 7 8 9 C; row3: E(*) 0 F(#) D.
  - Codes are the hex value of the key.
- FSM, evaluated once per scan end:
  - IDLE: SINGLE(k) -> DEBOUNCE with cand=k, cnt=1. Otherwise stay.
  - DEBOUNCE: SINGLE(cand) -> cnt+1. When cnt reaches DEB_SCANS -> PRESSED and emit event(cand). Any other class -> IDLE.
  - If DEB_SCANS=1, IDLE goes directly to PRESSED on the first SINGLE scan and emits.
  - PRESSED: key_held=1. NONE -> RELEASE with cnt=1. SINGLE(cand) and MULTI keep the state (MULTI is neither a press nor a release).
  - RELEASE: NONE -> cnt+1; at DEB_SCANS -> IDLE and key_held=0. SINGLE(cand) -> PRESSED with no new event. SINGLE(other) -> DEBOUNCE with the new cand.
- Event emission (one cycle after scan end):
  - If key_valid=0 or key_ready=1 that cycle, load key_code and set key_valid=1.
  - Otherwise drop the event and set overrun=1; key_code is not overwritten.
  - Accept with no new event clears key_valid next cycle. A new event on the same cycle as an accept keeps key_valid=1 and loads the new code.
- Accumulator update, on every emitted event whether or not it was dropped:
  - code 0x0-0xD: value <= {value[27:0], code}; the top nibble is discarded.
  - 0xE: value <= value >> 4.
  - 0xF: value <= 0.
- clr has priority over an accumulator update in the same cycle; clr does not affect the FSM or key_valid.
- Latency: the first press event appears DEB_SCANS full scans after the first scan that sees the key, plus 3 cycles (2 synchroniser + 1 emit).

Optional Feature:
KEYPAD_REPEAT_EN:
- Defined: in PRESSED, a scan counter counts SINGLE(cand) scans. A repeat event(cand) fires when the count reaches REPEAT_DELAY, then every REPEAT_RATE scans after that.
  - Repeat events follow the same handshake, overrun and accumulator rules as a press event.
  - The counter resets on leaving PRESSED.
- Undefined: exactly one event per press; repeat parameters are unused and the counter is not instantiated.

Decomposition:
- keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE, PRESSED, RELEASE};
  - scan-class enum {NONE, SINGLE, MULTI};
  - key code constants KEY_BKSP=4'hE and KEY_CLR=4'hF;
  - keymap function (row idx, col idx) -> 4-bit code.
- One sub-module, key_sync: parameterised-width 2-flop synchroniser with async active-high reset (resets to all-ones, i.e. idle columns); reused for col.

Test Plan (SCAN_DIV=4, DEB_SCANS=2, key_ready=1 unless noted):
- Reset mid-scan: assert rst during a row-2 slot -> row=4'b1110, key_valid=0, value=0 immediately, with no clock edge needed.
- Press "5": pull col[1] low whenever row[1]=0 -> exactly one key_valid pulse with key_code=4'h5 and value=32'h5. Held 20 scans -> no further events. Release -> key_held falls after 2 NONE scans.
- Keys 1,2,3,A,B,C,D,7,8 in sequence -> value=32'h23ABCD78 (leading 1 shifted out). Then "*" -> 32'h023ABCD7. Then "#" -> 32'h00000000.
- Bounce: key "9" present for 1 scan, absent 1 scan, present 1 scan -> no event. Two-key press of 1 and 6 -> no event and key_held stays 0.
- Backpressure: key_ready=0, press 4 then 8 -> key_valid=1, key_code=4'h4, overrun=1, value=32'h48. Then key_ready=1 for one cycle -> key_valid=0. clr -> overrun=0, value=0.
- KEYPAD_REPEAT_EN with REPEAT_DELAY=3, REPEAT_RATE=2: hold "0" for 8 scans after press -> events at press and at held-scan counts 3, 5 and 7 (4 events total), value=32'h0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key codes and key map for the 4x4 keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_e;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_e;

    localparam logic [3:0] KEY_BKSP = 4'hE;
    localparam logic [3:0] KEY_CLR  = 4'hF;

    // Entry {row, col}; row0: 1 2 3 A, row1: 4 5 6 B, row2: 7 8 9 C, row3: E 0 F D
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        return KEYMAP[{r, c}];
    endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: W-bit two-flop synchroniser, resets to all-ones (idle, pulled-up lines)
module key_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q, s2_q;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad scan, debounce, key events with valid/ready and a hex accumulator; KEYPAD_REPEAT_EN adds auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    , parameter int REPEAT_DELAY = 40
    , parameter int REPEAT_RATE  = 10
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_held,
    output logic        overrun,
    output logic [31:0] value,
    input  logic        clr
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEB_SCANS + 1);
    localparam logic [CW-1:0] DEB = CW'(DEB_SCANS);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [3:0]    col_s, low, code_now, hcode_q, cand_q, cand_d, ev_code_q, key_code_q, key_code_d;
    logic [DW-1:0] div_q;
    logic [1:0]    r_q, hits_q, hits_now, cidx;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]   value_q, value_d;
    logic          slot_end, scan_end, multi_row, emit_d, ev_q, rep_fire, take;
    logic          key_valid_q, key_valid_d, overrun_q, overrun_d;
    scan_e         cls;
    state_e        state_q, state_d;

    key_sync #(.W(4)) u_col_sync (.clk(clk), .rst(rst), .d_i(col), .q_o(col_s));

    assign low       = ~col_s;
    assign slot_end  = div_q == DW'(SCAN_DIV - 1);
    assign scan_end  = slot_end && r_q == 2'd3;
    assign multi_row = |(low & (low - 4'd1));
    assign cidx      = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
    assign hits_now  = multi_row ? 2'd2 : !(|low) ? hits_q : (hits_q == 2'd0) ? 2'd1 : 2'd2;
    assign code_now  = (hits_q == 2'd0) ? keymap(r_q, cidx) : hcode_q;
    assign cls       = (hits_now == 2'd0) ? NONE : (hits_now == 2'd1) ? SINGLE : MULTI;
    assign cnt_inc   = cnt_q + ONE;
    assign row       = ~(4'b0001 << r_q);

    // row slot timer and per-scan tally of low columns (0, 1, or many)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            r_q     <= '0;
            hits_q  <= '0;
            hcode_q <= '0;
        end else begin
            div_q <= slot_end ? '0 : div_q + 1'b1;
            if (slot_end) begin
                r_q     <= r_q + 2'd1;
                hits_q  <= scan_end ? 2'd0 : hits_now;
                hcode_q <= code_now;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    logic [RW-1:0] rep_q, rep_d;
    logic          rep_first_q, rep_first_d, rep_hit;

    assign rep_hit = scan_end && state_q == PRESSED && cls == SINGLE && code_now == cand_q;

    // held-scan counter: first repeat after REPEAT_DELAY scans, then every REPEAT_RATE
    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if (state_q != PRESSED) begin
            rep_d       = '0;
            rep_first_d = 1'b0;
        end else if (rep_hit) begin
            rep_fire    = (rep_q + 1'b1) == RW'(rep_first_q ? REPEAT_RATE : REPEAT_DELAY);
            rep_d       = rep_fire ? '0 : rep_q + 1'b1;
            rep_first_d = rep_first_q | rep_fire;
        end
    end

    // repeat counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q       <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // FSM state, candidate key and debounce count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state, advanced only on a classified scan
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        emit_d  = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                IDLE: if (cls == SINGLE) begin
                    cand_d  = code_now;
                    cnt_d   = ONE;
                    state_d = (DEB_SCANS == 1) ? PRESSED : DEBOUNCE;
                    emit_d  = DEB_SCANS == 1;
                end
                DEBOUNCE: if (cls == SINGLE && code_now == cand_q) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == DEB) ? PRESSED : DEBOUNCE;
                    emit_d  = cnt_inc == DEB;
                end else begin
                    state_d = IDLE;
                end
                PRESSED: if (cls == NONE) begin
                    cnt_d   = ONE;
                    state_d = (DEB_SCANS == 1) ? IDLE : RELEASE;
                end else begin
                    emit_d  = rep_fire;
                end
                RELEASE: if (cls == NONE) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == DEB) ? IDLE : RELEASE;
                end else if (cls == SINGLE) begin
                    state_d = (code_now == cand_q) ? PRESSED : DEBOUNCE;
                    cand_d  = code_now;
                    cnt_d   = (code_now == cand_q) ? cnt_q : ONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        key_held = state_q == PRESSED || state_q == RELEASE;
    end

    // event delivery: a pending unaccepted event blocks new ones, which are dropped and flagged
    always_comb begin
        take        = ev_q && (!key_valid_q || key_ready);
        key_valid_d = take ? 1'b1 : key_ready ? 1'b0 : key_valid_q;
        key_code_d  = take ? ev_code_q : key_code_q;
        overrun_d   = clr ? 1'b0 : (ev_q && !take) ? 1'b1 : overrun_q;
        value_d     = clr ? 32'd0 : !ev_q ? value_q :
                      (ev_code_q == KEY_CLR) ? 32'd0 :
                      (ev_code_q == KEY_BKSP) ? value_q >> 4 : {value_q[27:0], ev_code_q};
    end

    // event pipeline stage, handshake and accumulator registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_q        <= 1'b0;
            ev_code_q   <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            overrun_q   <= 1'b0;
            value_q     <= '0;
        end else begin
            ev_q        <= emit_d;
            ev_code_q   <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            overrun_q   <= overrun_d;
            value_q     <= value_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign value     = value_q;

endmodule
